// File: rtl/arm_pose_sequencer.sv
// Key-byte driven pose sequencer: decodes arm commands into clamped joint targets
// and slews shoulder/elbow/base toward them one bounded step per motion tick.

module arm_joint_slew #(
  parameter int ANGLE_W = 24,
  parameter int STEP    = 1000
) (
  input  logic [ANGLE_W-1:0] i_cur,
  input  logic [ANGLE_W-1:0] i_tgt,
  output logic [ANGLE_W-1:0] o_nxt,
  output logic               o_at_tgt
);
  localparam logic [ANGLE_W-1:0] STEP_V = ANGLE_W'(STEP);

  logic [ANGLE_W-1:0] w_nxt;

  // Targets are clamped well inside the range, so +/- STEP never wraps.
  always_comb begin
    w_nxt = i_cur;
    if (i_tgt > i_cur)
      w_nxt = ((i_tgt - i_cur) <= STEP_V) ? i_tgt : i_cur + STEP_V;
    else if (i_tgt < i_cur)
      w_nxt = ((i_cur - i_tgt) <= STEP_V) ? i_tgt : i_cur - STEP_V;
  end

  assign o_nxt    = w_nxt;
  assign o_at_tgt = (w_nxt == i_tgt);
endmodule

module arm_pose_sequencer #(
  parameter int ANGLE_W   = 24,
  parameter int STEP      = 1000,
  parameter int TICK_DIV  = 50000,
  parameter int BASE_STEP = 10000,
  parameter int ANGLE_MIN = 50000,
  parameter int ANGLE_MAX = 250000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cmd_valid,
  input  logic [7:0]         i_cmd_data,
  output logic               o_cmd_ready,
  output logic [ANGLE_W-1:0] o_shoulder_angle,
  output logic [ANGLE_W-1:0] o_elbow_angle,
  output logic [ANGLE_W-1:0] o_base_angle,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [1:0]         o_state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_MOVE = 2'd2} state_t;
  typedef logic [ANGLE_W:0] wide_t;

  localparam int NJ   = 3;
  localparam int J_SH = 0;
  localparam int J_EL = 1;
  localparam int J_BA = 2;
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [NJ-1:0][ANGLE_W-1:0] HOME = {ANGLE_W'(150000), ANGLE_W'(145000), ANGLE_W'(180000)};

  function automatic logic [ANGLE_W-1:0] clamp(input wide_t v);
    if (v < wide_t'(ANGLE_MIN)) return ANGLE_W'(ANGLE_MIN);
    if (v > wide_t'(ANGLE_MAX)) return ANGLE_W'(ANGLE_MAX);
    return v[ANGLE_W-1:0];
  endfunction

  function automatic logic key_mapped(input logic [7:0] b);
    case (b)
      8'h77, 8'h61, 8'h73, 8'h64, 8'h71, 8'h65, 8'h68: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  state_t                        r_state, w_state_nxt;
  logic [NJ-1:0][ANGLE_W-1:0]    r_cur, r_tgt, w_nxt, w_ld_tgt;
  logic [NJ-1:0]                 w_at_tgt;
  logic [7:0]                    r_dec, r_pend, w_load_byte;
  logic                          r_pend_full, w_pend_full_nxt;
  logic                          r_ready, r_busy, r_done, r_err;
  logic [TW-1:0]                 r_tick_cnt;
  logic                          w_tick, w_acc, w_direct, w_drain, w_all_at, w_ld_map, w_ld_eq;

  for (genvar j = 0; j < NJ; j++) begin : g_joint
    arm_joint_slew #(.ANGLE_W(ANGLE_W), .STEP(STEP)) u_slew (
      .i_cur    (r_cur[j]),
      .i_tgt    (r_tgt[j]),
      .o_nxt    (w_nxt[j]),
      .o_at_tgt (w_at_tgt[j])
    );
  end

  assign w_tick   = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_all_at = &w_at_tgt;

  // Key decode for the byte held in LOAD; unnamed joints keep their target.
  always_comb begin
    w_ld_tgt = r_tgt;
    w_ld_map = 1'b1;
    case (r_dec)
      8'h77: begin w_ld_tgt[J_EL] = clamp(wide_t'(55000));  w_ld_tgt[J_SH] = clamp(wide_t'(180000)); end
      8'h61: begin w_ld_tgt[J_EL] = clamp(wide_t'(100000)); w_ld_tgt[J_SH] = clamp(wide_t'(179000)); end
      8'h73: begin w_ld_tgt[J_EL] = clamp(wide_t'(145000)); w_ld_tgt[J_SH] = clamp(wide_t'(181000)); end
      8'h64: begin w_ld_tgt[J_EL] = clamp(wide_t'(185000)); w_ld_tgt[J_SH] = clamp(wide_t'(178000)); end
      8'h71: w_ld_tgt[J_BA] = (r_tgt[J_BA] < ANGLE_W'(BASE_STEP)) ? clamp(wide_t'(0))
                              : clamp({1'b0, r_tgt[J_BA] - ANGLE_W'(BASE_STEP)});
      8'h65: w_ld_tgt[J_BA] = clamp({1'b0, r_tgt[J_BA]} + wide_t'(BASE_STEP));
      8'h68: for (int j = 0; j < NJ; j++) w_ld_tgt[j] = clamp({1'b0, HOME[j]});
      default: w_ld_map = 1'b0;
    endcase
  end

  assign w_ld_eq = (w_ld_tgt == r_cur);

  // The pending slot drains in IDLE, or when a move finishes on a tick.
  always_comb begin
    w_acc       = i_cmd_valid && r_ready;
    w_direct    = w_acc && (r_state == S_IDLE) && !r_pend_full;
    w_drain     = r_pend_full && ((r_state == S_IDLE) ||
                  ((r_state == S_MOVE) && w_tick && w_all_at));
    w_load_byte = w_drain ? r_pend : i_cmd_data;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_pend_full || w_acc) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = (!w_ld_map || w_ld_eq) ? S_IDLE : S_MOVE;
      S_MOVE: if (w_tick && w_all_at) w_state_nxt = r_pend_full ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_pend_full_nxt = (r_pend_full && !w_drain) || (w_acc && !w_direct);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur       <= HOME;
      r_tgt       <= HOME;
      r_dec       <= 8'h00;
      r_pend      <= 8'h00;
      r_pend_full <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tick_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_ready     <= !w_pend_full_nxt;
      r_busy      <= (w_state_nxt != S_IDLE) || w_pend_full_nxt;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_acc && !w_direct) r_pend <= i_cmd_data;
      // err is flagged on entry so it is visible during the LOAD cycle itself.
      if (w_state_nxt == S_LOAD) begin
        r_dec <= w_load_byte;
        r_err <= !key_mapped(w_load_byte);
      end
      case (r_state)
        S_LOAD: begin
          r_tgt <= w_ld_tgt;
          if (w_ld_map && w_ld_eq) r_done <= 1'b1;
        end
        S_MOVE: if (w_tick) begin
          r_cur <= w_nxt;
          if (w_all_at) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready      = r_ready;
  assign o_shoulder_angle = r_cur[J_SH];
  assign o_elbow_angle    = r_cur[J_EL];
  assign o_base_angle     = r_cur[J_BA];
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_state          = r_state;
endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Directed bench for arm_pose_sequencer: a STEP=1000 instance for most scenarios
// and a STEP=7000 instance for the coarse-step snap case.

module tb_arm_pose_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [7:0]  d1 = 8'h00, d2 = 8'h00;
  logic        rdy1, busy1, done1, err1, rdy2, busy2, done2, err2;
  logic [23:0] sh1, el1, ba1, sh2, el2, ba2;
  logic [1:0]  st1, st2;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  arm_pose_sequencer #(.ANGLE_W(24), .STEP(1000), .TICK_DIV(4), .BASE_STEP(10000),
                       .ANGLE_MIN(50000), .ANGLE_MAX(200000)) dut (
    .clk(clk), .reset(reset), .i_cmd_valid(v1), .i_cmd_data(d1), .o_cmd_ready(rdy1),
    .o_shoulder_angle(sh1), .o_elbow_angle(el1), .o_base_angle(ba1),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_state(st1));

  arm_pose_sequencer #(.ANGLE_W(24), .STEP(7000), .TICK_DIV(4), .BASE_STEP(10000),
                       .ANGLE_MIN(50000), .ANGLE_MAX(200000)) dut7 (
    .clk(clk), .reset(reset), .i_cmd_valid(v2), .i_cmd_data(d2), .o_cmd_ready(rdy2),
    .o_shoulder_angle(sh2), .o_elbow_angle(el2), .o_base_angle(ba2),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_state(st2));

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Returns at the negedge after the accepting edge (the LOAD cycle for a direct accept).
  task automatic send(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk); v1 = 1'b1; d1 = b;
    for (int i = 0; i < 3000; i++) begin
      if (rdy1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk); v1 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (st1 !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", st1); end
    total++; if (sh1 !== 24'd180000 || el1 !== 24'd145000 || ba1 !== 24'd150000) begin
      bad++; $display("FAIL rst_home got=%0d/%0d/%0d exp=180000/145000/150000", sh1, el1, ba1); end
    total++; if ({rdy1, busy1, done1, err1} !== 4'b1000) begin
      bad++; $display("FAIL rst_flags got=%b exp=1000", {rdy1, busy1, done1, err1}); end
    total++; if ({rdy2, st2} !== 3'b100) begin bad++; $display("FAIL rst_dut7 got=%b exp=100", {rdy2, st2}); end
  endtask

  task automatic test_w();
    bit ok; int steps = 0, stepbad = 0, shbad = 0, dn = 0;
    logic [23:0] prev;
    do_reset();
    send(8'h77, ok);
    total++; if (!ok) begin bad++; $display("FAIL w_accept got=0 exp=1"); end
    total++; if (st1 !== 2'd1) begin bad++; $display("FAIL w_load got=%0d exp=1", st1); end
    @(negedge clk);
    total++; if (st1 !== 2'd2) begin bad++; $display("FAIL w_move got=%0d exp=2", st1); end
    prev = el1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (el1 !== prev) begin
        steps++;
        if (prev - el1 !== 24'd1000) stepbad++;
        prev = el1;
      end
      if (sh1 !== 24'd180000) shbad++;
      if (done1) dn++;
      if (dn > 0 && i > 400) break;
    end
    total++; if (steps != 90) begin bad++; $display("FAIL w_steps got=%0d exp=90", steps); end
    total++; if (stepbad != 0) begin bad++; $display("FAIL w_stepsize got=%0d exp=0", stepbad); end
    total++; if (shbad != 0) begin bad++; $display("FAIL w_shoulder_hold got=%0d exp=0", shbad); end
    total++; if (el1 !== 24'd55000) begin bad++; $display("FAIL w_elbow got=%0d exp=55000", el1); end
    total++; if (dn != 1) begin bad++; $display("FAIL w_done_count got=%0d exp=1", dn); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL w_busy got=%0d exp=0", busy1); end
  endtask

  task automatic test_step7();
    int k = 0, earlydone = 0;
    logic [23:0] prev;
    do_reset();
    @(negedge clk); v2 = 1'b1; d2 = 8'h61;
    @(negedge clk); v2 = 1'b0;
    prev = el2;
    for (int i = 0; i < 200 && k < 7; i++) begin
      @(negedge clk);
      if (el2 !== prev) begin
        k++;
        total++; if (el2 !== ((k < 7) ? 24'(145000 - 7000 * k) : 24'd100000)) begin
          bad++; $display("FAIL a7_elbow tick=%0d got=%0d", k, el2); end
        if (k == 1) begin
          total++; if (sh2 !== 24'd179000) begin bad++; $display("FAIL a7_shoulder got=%0d exp=179000", sh2); end
        end
        if (k == 7) begin
          total++; if (done2 !== 1'b1) begin bad++; $display("FAIL a7_done got=%0d exp=1", done2); end
        end
        prev = el2;
      end
      if (done2 && k < 7) earlydone++;
    end
    total++; if (k != 7 || earlydone != 0) begin
      bad++; $display("FAIL a7_ticks got=%0d early=%0d exp=7/0", k, earlydone); end
  endtask

  task automatic test_e_clamp();
    bit ok; bit seen;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      send(8'h65, ok);
      if (k == 6) begin
        total++; if (st1 !== 2'd1) begin bad++; $display("FAIL e6_load got=%0d exp=1", st1); end
        @(negedge clk);
        total++; if ({st1, done1} !== 3'b001) begin bad++; $display("FAIL e6_idle_done got=%b exp=001", {st1, done1}); end
      end else begin
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (done1) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL e_done_timeout cmd=%0d", k); end
      end
      total++; if (ba1 !== ((k < 6) ? 24'(150000 + 10000 * k) : 24'd200000)) begin
        bad++; $display("FAIL e_base cmd=%0d got=%0d", k, ba1); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, accepted = 1'b0; int dn = 0, acc_dn = -1;
    do_reset();
    send(8'h77, ok);
    repeat (3) @(negedge clk);
    send(8'h73, ok);
    total++; if (!ok || st1 !== 2'd2) begin bad++; $display("FAIL q_s_accept ok=%0d state=%0d exp=1/2", ok, st1); end
    total++; if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++; $display("FAIL q_ready_drop got=%b exp=01", {rdy1, busy1}); end
    v1 = 1'b1; d1 = 8'h64;
    for (int i = 0; i < 2000; i++) begin
      if (done1) begin
        dn++;
        if (dn == 1) begin
          total++; if (el1 !== 24'd55000 || sh1 !== 24'd180000 || st1 !== 2'd1) begin
            bad++; $display("FAIL q_w_done got=%0d/%0d st=%0d exp=55000/180000/1", el1, sh1, st1); end
        end else if (dn == 2) begin
          total++; if (el1 !== 24'd145000 || sh1 !== 24'd181000) begin
            bad++; $display("FAIL q_s_done got=%0d/%0d exp=145000/181000", el1, sh1); end
        end else begin
          total++; if (el1 !== 24'd185000 || sh1 !== 24'd178000 || busy1 !== 1'b0) begin
            bad++; $display("FAIL q_d_done got=%0d/%0d busy=%0d exp=185000/178000/0", el1, sh1, busy1); end
          break;
        end
      end
      if (v1 && rdy1 && !accepted) begin accepted = 1'b1; acc_dn = dn; end
      @(negedge clk);
      if (accepted) v1 = 1'b0;
    end
    v1 = 1'b0;
    total++; if (dn != 3) begin bad++; $display("FAIL q_done_count got=%0d exp=3", dn); end
    total++; if (acc_dn != 1) begin bad++; $display("FAIL q_d_stall got=%0d exp=1", acc_dn); end
  endtask

  task automatic test_err();
    bit ok;
    do_reset();
    send(8'h41, ok);
    total++; if ({err1, st1, done1} !== 4'b1010) begin
      bad++; $display("FAIL err_load got=%b exp=1010", {err1, st1, done1}); end
    @(negedge clk);
    total++; if ({err1, st1, done1, busy1} !== 5'b00000) begin
      bad++; $display("FAIL err_idle got=%b exp=00000", {err1, st1, done1, busy1}); end
    total++; if (sh1 !== 24'd180000 || el1 !== 24'd145000 || ba1 !== 24'd150000) begin
      bad++; $display("FAIL err_angles got=%0d/%0d/%0d", sh1, el1, ba1); end
  endtask

  task automatic test_reset_mid_move();
    bit ok; int extra = 0;
    do_reset();
    send(8'h64, ok);
    repeat (30) @(negedge clk);
    total++; if (st1 !== 2'd2 || el1 === 24'd145000) begin
      bad++; $display("FAIL rm_moving st=%0d el=%0d", st1, el1); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    total++; if (sh1 !== 24'd180000 || el1 !== 24'd145000 || ba1 !== 24'd150000) begin
      bad++; $display("FAIL rm_home got=%0d/%0d/%0d", sh1, el1, ba1); end
    total++; if ({st1, rdy1, done1, busy1} !== 5'b00100) begin
      bad++; $display("FAIL rm_flags got=%b exp=00100", {st1, rdy1, done1, busy1}); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1 || el1 !== 24'd145000 || st1 !== 2'd0) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL rm_quiet got=%0d exp=0", extra); end
  endtask

  initial begin
    test_reset();
    test_w();
    test_step7();
    test_e_clamp();
    test_back_to_back();
    test_err();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arm_pose_sequencer.md
# arm_pose_sequencer

Command scheduler between the UART byte receiver and the servo PWM generators of the robot arm. It accepts key bytes over a valid/ready handshake and maps each one to a target pose for the shoulder, elbow and base joints. It slews the three 24-bit angle outputs toward that target at a fixed step per motion tick, so the servos never see a jump. It holds one further command in a pending slot while a move is in progress.

## Interface
- ANGLE_W, 24, width of angle values (servo pulse width in clk counts)
- STEP, 1000, maximum change per joint per motion tick
- TICK_DIV, 50000, clk cycles per motion tick
- BASE_STEP, 10000, base target increment for 'q'/'e'
- ANGLE_MIN, 50000, lower clamp for every target
- ANGLE_MAX, 250000, upper clamp for every target
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  cmd_data is valid
- cmd_data  in  8  ASCII key byte
- cmd_ready  out  1  block can accept a byte this cycle
- shoulder_angle  out  ANGLE_W  current shoulder command
- elbow_angle  out  ANGLE_W  current elbow command
- base_angle  out  ANGLE_W  current base command
- busy  out  1  state != IDLE or pending slot full
- done  out  1  one-cycle pulse when a move completes
- err  out  1  one-cycle pulse when an unmapped byte is decoded
- state  out  2  IDLE=0, LOAD=1, MOVE=2

## Operation
- Reset (clk is the only clock; reset is synchronous, active-high):
  - shoulder = 180000, elbow = 145000, base = 150000 (home); targets equal home.
  - Pending slot empty; tick counter = 0; state IDLE.
  - cmd_ready = 1; busy, done and err = 0.
- Handshake: a byte is accepted on an edge where cmd_valid && cmd_ready. cmd_ready = !pending_full, registered.
  - Byte accepted in IDLE with the slot empty: it goes directly to the decode register and the state moves to LOAD.
  - Otherwise: the byte fills the pending slot.
- LOAD (1 cycle): decode the byte, clamp each target to [ANGLE_MIN, ANGLE_MAX].
  - 0x77 'w': elbow 55000, shoulder 180000.
  - 0x61 'a': elbow 100000, shoulder 179000.
  - 0x73 's': elbow 145000, shoulder 181000.
  - 0x64 'd': elbow 185000, shoulder 178000.
  - 0x71 'q': base target −= BASE_STEP. 0x65 'e': base target += BASE_STEP. Both are relative to the current base target.
  - 0x68 'h': full home pose.
  - Joints not named by a key keep their target.
  - Unmapped byte: err pulse, targets unchanged, exit as below.
  - Exit: if all targets equal the current angles, go to IDLE with a done pulse (no done pulse for an unmapped byte). Otherwise go to MOVE.
- MOVE, on each tick, per joint:
  - If |target − cur| ≤ STEP: cur = target.
  - Otherwise: cur ±= STEP toward target.
  - Arithmetic is unsigned at ANGLE_W with no wrap. Clamping guarantees this.
  - When all joints equal target after the update: done pulses the next cycle. The state goes to LOAD if the pending slot is full (the slot moves into the decode register and is freed), else to IDLE.
- Tick counter:
  - Free-running, 0..TICK_DIV−1; tick is high when count == TICK_DIV−1.
  - Not restarted on command accept, so the first step lands 1..TICK_DIV cycles after entering MOVE.
- Simultaneous events:
  - Accept on the same edge as the slot drains to LOAD: the new byte fills the slot, with no loss.
  - A byte in the pending slot never overwrites the decode register mid-move.

## Timing
- Accept at edge N → state LOAD in cycle N+1 → MOVE (or IDLE) in cycle N+2.
- Angle outputs are registered and change only on tick edges in MOVE. There are no combinational paths from the inputs to the outputs.
- done and err are exactly one cycle wide.
- Reset mid-move: the next cycle shows home angles, IDLE, an empty slot and cmd_ready = 1. No done pulse.

## Test plan
- Bench parameters: TICK_DIV=4, STEP=1000, ANGLE_MAX=200000.
- Reset, send 'w' → elbow falls 145000→55000 in 1000 steps over 90 ticks (≈360 cycles); shoulder holds 180000; one done pulse; busy low afterwards.
- With STEP=7000, send 'a' from home → elbow goes 145000, 138000, …, 103000, then snaps to 100000 on tick 7; shoulder reaches 179000 on tick 1; done after tick 7.
- Send 'e' six times from home, waiting for done each time → base = 160000, 170000, 180000, 190000, 200000, then 200000 again (clamped). The sixth command goes LOAD→IDLE with done and no MOVE cycles.
- Send 'w', then 's' during MOVE, then 'd' → cmd_ready drops after 's' and 'd' is stalled. After 'w' completes, 's' runs (elbow back to 145000, shoulder 181000) and 'd' is then accepted.
- Send 0x41 → err pulses one cycle in LOAD; angles unchanged; no done; IDLE two cycles after accept.
- Assert reset for one cycle mid-way through a 'd' move → home angles on the next cycle, state 0, cmd_ready 1, no done pulse.
